// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and constants for the RV64M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on unsigned magnitudes.
module muldiv_iter_step #(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_is_div,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_q_bit
);

    logic [XLEN:0] w_mul_sum;
    logic [XLEN:0] w_rem_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        o_acc       = '0;
        o_q_bit     = 1'b0;
        w_mul_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_rem_shift = i_acc[2*XLEN-1:XLEN-1];
        w_diff      = w_rem_shift - {1'b0, i_operand};
        w_fits      = ~w_diff[XLEN];
        if (i_is_div) begin
            // Quotient bit is returned separately; the freed LSB is left zero for the caller to fill.
            o_q_bit = w_fits;
            o_acc   = {(w_fits ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0]), i_acc[XLEN-2:0], 1'b0};
        end else begin
            o_acc   = {w_mul_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide unit: latches one op, stalls the pipe, pulses done with the result.
module muldiv_sequencer #(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int CNT_W = muldiv_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(XLEN - 1);

    md_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_is_div, w_is_rem, w_a_signed, w_b_signed, w_sa, w_sb;
    logic              w_div_zero, w_overflow, w_step_q;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_shortcut, w_fixed, w_quo, w_rem;
    logic [2*XLEN-1:0] w_prod, w_step_acc;

    assign w_is_div   = r_funct3[2];
    assign w_is_rem   = r_funct3[2] & r_funct3[1];
    assign w_a_signed = (r_funct3 == MD_MULH) || (r_funct3 == MD_MULHSU) ||
                        (r_funct3 == MD_DIV)  || (r_funct3 == MD_REM);
    assign w_b_signed = (r_funct3 == MD_MULH) || (r_funct3 == MD_DIV) || (r_funct3 == MD_REM);
    assign w_sa       = w_a_signed & r_opa[XLEN-1];
    assign w_sb       = w_b_signed & r_opb[XLEN-1];
    assign w_abs_a    = w_sa ? -r_opa : r_opa;
    assign w_abs_b    = w_sb ? -r_opb : r_opb;
    assign w_div_zero = w_is_div && (r_opb == '0);
    assign w_overflow = w_is_div && w_b_signed && (r_opa == MOST_NEG) && (r_opb == ALL_ONES);
    assign w_shortcut = w_div_zero ? (w_is_rem ? r_opa : ALL_ONES) : (w_is_rem ? '0 : r_opa);

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_opb),
        .i_is_div  (w_is_div),
        .o_acc     (w_step_acc),
        .o_q_bit   (w_step_q)
    );

    always_comb begin
        w_prod  = r_neg ? -r_acc : r_acc;
        w_quo   = r_acc[XLEN-1:0];
        w_rem   = r_acc[2*XLEN-1:XLEN];
        w_fixed = '0;
        case (r_funct3)
            MD_MUL:                       w_fixed = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_fixed = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_fixed = r_neg ? -w_quo : w_quo;
            default:                      w_fixed = r_neg ? -w_rem : w_rem;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_funct3 <= funct3;
                        r_opa    <= rs1_data;
                        r_opb    <= rs2_data;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (w_div_zero || w_overflow) begin
                        r_result <= w_shortcut;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                        r_opb   <= w_abs_b;
                        r_neg   <= w_is_rem ? w_sa : (w_sa ^ w_sb);
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_step_q};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == L_LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fixed;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign stall_req = (start && (r_state == S_IDLE)) ||
                       (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
    assign done      = r_done;
    assign result    = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed vector table, flush/reset/back-to-back sequences, random ops vs model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic            clk = 1'b0;
    logic            rst, start, flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            busy, stall_req, done;
    logic [XLEN-1:0] result;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    localparam int N_VEC = 13;
    vec_t vecs[N_VEC];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: plain 128-bit / signed arithmetic plus the RISC-V special cases.
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0]      ea, eb, prod;
        logic signed [XLEN-1:0] sa, sb;
        logic                   ovf;
        sa   = a;
        sb   = b;
        ovf  = (a == MOST_NEG) && (b == ALL_ONES);
        ea   = (f3 == MD_MULH || f3 == MD_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb   = (f3 == MD_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        prod = ea * eb;
        case (f3)
            MD_MUL:                       return prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: return prod[2*XLEN-1:XLEN];
            MD_DIV:  return (b == 0) ? ALL_ONES : (ovf ? a : XLEN'(sa / sb));
            MD_DIVU: return (b == 0) ? ALL_ONES : a / b;
            MD_REM:  return (b == 0) ? a : (ovf ? '0 : XLEN'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        logic sgn_div;
        sgn_div = (f3 == MD_DIV) || (f3 == MD_REM);
        if (f3[2] && ((b == 0) || (sgn_div && a == MOST_NEG && b == ALL_ONES))) return 2;
        return XLEN + 3;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output logic [XLEN-1:0] res, output int lat, output int bad);
        bad = 0;
        lat = 0;
        res = '0;
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
        #1;
        if (stall_req !== 1'b1) bad++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rs1_data = {$urandom, $urandom};
        rs2_data = {$urandom, $urandom};
        for (int k = 1; k <= 200; k++) begin
            if (done === 1'b1) begin
                lat = k;
                res = result;
                if (stall_req !== 1'b0 || busy !== 1'b1) bad++;
                break;
            end
            if (stall_req !== 1'b1 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) bad++;
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        logic [XLEN-1:0] res;
        int              lat, bad;
        run_op(f3, a, b, res, lat, bad);
        check({name, "_result"}, res, exp);
        check({name, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
        check({name, "_stall_busy"}, XLEN'(bad), '0);
    endtask

    initial begin
        logic [XLEN-1:0] prev, ra, rb;
        logic [2:0]      rf;

        vecs[0]  = '{MD_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67};
        vecs[1]  = '{MD_MULHU,  ALL_ONES, ALL_ONES, 64'hFFFF_FFFF_FFFF_FFFE, 67};
        vecs[2]  = '{MD_MULH,   ALL_ONES, ALL_ONES, 64'd0, 67};
        vecs[3]  = '{MD_MULHSU, ALL_ONES, 64'd2, ALL_ONES, 67};
        vecs[4]  = '{MD_DIV,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 67};
        vecs[5]  = '{MD_REM,    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 67};
        vecs[6]  = '{MD_DIVU,   64'd100, 64'd7, 64'd14, 67};
        vecs[7]  = '{MD_REMU,   64'd100, 64'd7, 64'd2, 67};
        vecs[8]  = '{MD_DIVU,   64'd13, 64'd0, ALL_ONES, 2};
        vecs[9]  = '{MD_REM,    64'd13, 64'd0, 64'd13, 2};
        vecs[10] = '{MD_DIV,    MOST_NEG, ALL_ONES, MOST_NEG, 2};
        vecs[11] = '{MD_REM,    MOST_NEG, ALL_ONES, 64'd0, 2};
        vecs[12] = '{MD_MUL,    64'd3, 64'd4, 64'd12, 67};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", XLEN'(busy), '0);
        check("reset_done", XLEN'(done), '0);
        check("reset_stall", XLEN'(stall_req), '0);
        check("reset_result", result, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N_VEC; i++)
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        prev = vecs[N_VEC-1].exp;

        // Flush in the 10th CALC cycle (cycle 11 after the accepting edge).
        start = 1'b1; funct3 = MD_MUL; rs1_data = 64'd5; rs2_data = 64'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", XLEN'(busy), '0);
        check("flush_done", XLEN'(done), '0);
        check("flush_result_kept", result, prev);
        @(negedge clk);
        check("flush_no_late_done", XLEN'(done), '0);
        do_op("after_flush_mul", MD_MUL, 64'd3, 64'd4, 64'd12, 67);

        // flush and start together in IDLE: op must not be accepted.
        start = 1'b1; flush = 1'b1; funct3 = MD_DIVU; rs1_data = 64'd50; rs2_data = 64'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", XLEN'(busy), '0);
        @(negedge clk);
        check("flush_start_result", result, 64'd12);

        // Reset mid-CALC.
        start = 1'b1; funct3 = MD_DIVU; rs1_data = 64'd1000; rs2_data = 64'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", XLEN'(busy), '0);
        check("midrst_done", XLEN'(done), '0);
        check("midrst_stall", XLEN'(stall_req), '0);
        check("midrst_result", result, '0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each op starts in the idle cycle right after the previous done.
        do_op("b2b_0", MD_DIVU, 64'd13, 64'd0, ALL_ONES, 2);
        do_op("b2b_1", MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67);
        do_op("b2b_2", MD_REMU, 64'd100, 64'd7, 64'd2, 67);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = MOST_NEG; rb = ALL_ONES; end
                2: rb = XLEN'($urandom_range(1, 1000));
                3: ra = XLEN'($urandom_range(0, 1000));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), rf, ra, rb, ref_result(rf, ra, rb), ref_latency(rf, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
